// File: rtl/aes_round_sequencer_if.sv
// ============================================================================
//  Module      : aes_round_sequencer_if
//  Description : Request, result and datapath-control bundle for the AES
//                round sequencer. The slave modport is the sequencer side;
//                the master modport is the requester / consumer / datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_round_sequencer_if;
    // Request port (bit 0 of a 128-bit block is its MSB)
    logic         req_valid;
    logic         req_ready;
    logic         req_mode;
    logic [0:127] req_data;

    // Round datapath controls and state feedback
    logic         dp_load;
    logic [0:127] dp_state_in;
    logic         dp_round_en;
    logic         dp_final;
    logic         dp_mode;
    logic [3:0]   dp_key_idx;
    logic [0:127] dp_state;

    // Result port and status
    logic         res_valid;
    logic         res_ready;
    logic [0:127] res_data;
    logic         busy;
    logic [7:0]   jobs_done;

    modport slave (
        input  req_valid, req_mode, req_data, res_ready, dp_state,
        output req_ready, dp_load, dp_state_in, dp_round_en, dp_final,
               dp_mode, dp_key_idx, res_valid, res_data, busy, jobs_done
    );

    modport master (
        output req_valid, req_mode, req_data, res_ready, dp_state,
        input  req_ready, dp_load, dp_state_in, dp_round_en, dp_final,
               dp_mode, dp_key_idx, res_valid, res_data, busy, jobs_done
    );
endinterface

`default_nettype wire

// File: rtl/aes_round_sequencer.sv
// ============================================================================
//  Module      : aes_round_sequencer
//  Description : Walks one shared AES round datapath through a full encrypt
//                or decrypt job: load + initial AddRoundKey, Nr-1 full
//                rounds, one final round, then holds the result until the
//                consumer takes it. Round-key indices only; key expansion
//                lives outside.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_sequencer #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  wire logic            clk,
    input  wire logic            reset,
    aes_round_sequencer_if.slave bus
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOAD  = 3'd1;
    localparam logic [2:0] c_ROUND = 3'd2;
    localparam logic [2:0] c_FINAL = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [3:0] c_LAST_KEY = 4'(Nr);
    localparam logic [3:0] c_LAST_RND = 4'(Nr - 1);

    logic [2:0]   r_state;
    logic [2:0]   w_nextState;
    logic [3:0]   r_rnd;
    logic [0:127] r_data;
    logic         r_mode;
    logic [0:127] r_resData;
    logic [7:0]   r_jobsDone;

    logic         w_reqReady;
    logic         w_busy;
    logic         w_load;
    logic         w_roundEn;
    logic         w_final;
    logic         w_resValid;
    logic [3:0]   w_keyIdx;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; any unused encoding falls back to IDLE
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (bus.req_valid) w_nextState = c_LOAD;
            c_LOAD:  w_nextState = c_ROUND;
            // >= rather than == so a corrupted counter cannot run past the key table
            c_ROUND: if (r_rnd >= c_LAST_RND) w_nextState = c_FINAL;
            c_FINAL: w_nextState = c_DONE;
            c_DONE:  if (bus.res_ready) w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    // Moore control outputs, decoded from the state register only
    always_comb begin
        w_reqReady = 1'b0;
        w_busy     = 1'b1;
        w_load     = 1'b0;
        w_roundEn  = 1'b0;
        w_final    = 1'b0;
        w_resValid = 1'b0;
        w_keyIdx   = 4'd0;
        case (r_state)
            c_IDLE: begin
                w_reqReady = 1'b1;
                w_busy     = 1'b0;
            end
            c_LOAD: begin
                w_load   = 1'b1;
                w_keyIdx = r_mode ? c_LAST_KEY : 4'd0;
            end
            c_ROUND: begin
                w_roundEn = 1'b1;
                w_keyIdx  = r_mode ? (c_LAST_KEY - r_rnd) : r_rnd;
            end
            c_FINAL: begin
                w_roundEn = 1'b1;
                w_final   = 1'b1;
                w_keyIdx  = r_mode ? 4'd0 : c_LAST_KEY;
            end
            c_DONE: begin
                w_resValid = 1'b1;
            end
            default: begin
                w_busy = 1'b1;
            end
        endcase
    end

    // Round counter: starts at 1 on load, steps once per full round
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rnd <= 4'd0;
        end else if (r_state == c_LOAD) begin
            r_rnd <= 4'd1;
        end else if (r_state == c_ROUND) begin
            r_rnd <= r_rnd + 4'd1;
        end else if (r_state == c_IDLE) begin
            r_rnd <= 4'd0;
        end
    end

    // Request capture; requests outside IDLE are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_mode <= 1'b0;
        end else if (r_state == c_IDLE && bus.req_valid) begin
            r_data <= bus.req_data;
            r_mode <= bus.req_mode;
        end
    end

    // Result capture and completed-job counter (wraps naturally at 8 bits)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resData  <= '0;
            r_jobsDone <= 8'd0;
        end else if (r_state == c_DONE) begin
            r_resData <= bus.dp_state;
            if (bus.res_ready) begin
                r_jobsDone <= r_jobsDone + 8'd1;
            end
        end
    end

    // The datapath register already holds the final-round state on the first
    // DONE cycle and stays idle throughout DONE, so it is forwarded directly
    // there; the captured copy keeps the last result visible afterwards.
    assign bus.res_data    = (r_state == c_DONE) ? bus.dp_state : r_resData;

    assign bus.req_ready   = w_reqReady;
    assign bus.busy        = w_busy;
    assign bus.dp_load     = w_load;
    assign bus.dp_round_en = w_roundEn;
    assign bus.dp_final    = w_final;
    assign bus.res_valid   = w_resValid;
    assign bus.dp_key_idx  = w_keyIdx;
    assign bus.dp_mode     = r_mode;
    assign bus.dp_state_in = r_data;
    assign bus.jobs_done   = r_jobsDone;

endmodule

`default_nettype wire
